// File: rtl/mersenne_pkg.sv
// mersenne_pkg: mode codes, FSM states and the 2^W-1 reduction
// shared by the modular unit and anything that needs a reference fold.
package mersenne_pkg;

  localparam logic [1:0] MODE_MUL = 2'b00;
  localparam logic [1:0] MODE_DIV = 2'b01;
  localparam logic [1:0] MODE_INV = 2'b10;
  localparam logic [1:0] MODE_RSV = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INV,
    S_MUL,
    S_DONE
  } state_t;

  // Fold a 2w-bit product into 0..2^w-2 using 2^w == 1 (mod p).
  function automatic logic [63:0] mersenne_fold(
    input logic [127:0] prod,
    input int           w
  );
    logic [127:0] mask;
    logic [127:0] lo;
    logic [127:0] hi;
    logic [127:0] s;
    mask = (128'd1 << w) - 128'd1;
    lo   = prod & mask;
    hi   = (prod >> w) & mask;
    s    = lo + hi;
    if (((s >> w) & 128'd1) != 128'd0)
      s = (s & mask) + 128'd1;
    if (s == mask)
      s = '0;
    return s[63:0];
  endfunction

endpackage

// File: rtl/mersenne_moddiv_if.sv
// mersenne_moddiv_if: request/response bundle of the modular unit.
// master drives requests, slave (the unit) returns result and flags.
interface mersenne_moddiv_if #(
  parameter int W = 31
);
  logic         start;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] result;
  logic         div_by_zero;
  logic         illegal_mode;

  modport master (
    output start,
    output mode,
    output a,
    output b,
    input  ready,
    input  done,
    input  result,
    input  div_by_zero,
    input  illegal_mode
  );

  modport slave (
    input  start,
    input  mode,
    input  a,
    input  b,
    output ready,
    output done,
    output result,
    output div_by_zero,
    output illegal_mode
  );
endinterface

// File: rtl/mersenne_inv.sv
// mersenne_inv: binary extended Euclid inverse mod 2^W-1,
// one reduction step per clock while busy.
module mersenne_inv #(
  parameter int W = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         fin,
  output logic [W-1:0] inv
);

  localparam logic [W:0] P   = {1'b0, {W{1'b1}}};
  localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

  logic [W:0] r_u;
  logic [W:0] r_v;
  logic [W:0] r_x1;
  logic [W:0] r_x2;
  logic       r_busy;

  logic [W:0] w_u;
  logic [W:0] w_v;
  logic [W:0] w_x1;
  logic [W:0] w_x2;
  logic       w_uev;
  logic       w_vev;
  logic       w_uge;
  logic       w_fin;

  // x/2 mod p; W+1 bits keep x+p from overflowing.
  function automatic logic [W:0] halve(input logic [W:0] x);
    logic [W:0] t;
    t = x[0] ? (x + P) : x;
    return t >> 1;
  endfunction

  function automatic logic [W:0] submod(
    input logic [W:0] x,
    input logic [W:0] y
  );
    return (x >= y) ? (x - y) : (x - y + P);
  endfunction

  assign w_uev = ~r_u[0];
  assign w_vev = r_u[0] & ~r_v[0];
  assign w_uge = r_u[0] & r_v[0] & (r_u >= r_v);

  always_comb begin
    w_u  = r_u;
    w_v  = r_v;
    w_x1 = r_x1;
    w_x2 = r_x2;
    unique case (1'b1)
      w_uev: begin
        w_u  = r_u >> 1;
        w_x1 = halve(r_x1);
      end
      w_vev: begin
        w_v  = r_v >> 1;
        w_x2 = halve(r_x2);
      end
      w_uge: begin
        w_u  = r_u - r_v;
        w_x1 = submod(r_x1, r_x2);
      end
      default: begin
        w_v  = r_v - r_u;
        w_x2 = submod(r_x2, r_x1);
      end
    endcase
  end

  assign w_fin = r_busy && ((r_u == ONE) || (r_v == ONE));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_u    <= '0;
      r_v    <= '0;
      r_x1   <= '0;
      r_x2   <= '0;
      r_busy <= 1'b0;
    end else if (go) begin
      r_u    <= {1'b0, b};
      r_v    <= P;
      r_x1   <= ONE;
      r_x2   <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (w_fin) begin
        r_busy <= 1'b0;
      end else begin
        r_u  <= w_u;
        r_v  <= w_v;
        r_x1 <= w_x1;
        r_x2 <= w_x2;
      end
    end
  end

  assign busy = r_busy;
  assign fin  = w_fin;
  assign inv  = (r_u == ONE) ? r_x1[W-1:0] : r_x2[W-1:0];

endmodule

// File: rtl/mersenne_moddiv.sv
// mersenne_moddiv: multiply, divide or invert modulo p = 2^W-1
// behind a start/ready/done handshake with error reporting.
module mersenne_moddiv
  import mersenne_pkg::*;
#(
  parameter int W    = 31,
  parameter int MAXC = 4*W+4
) (
  input logic              clk,
  input logic              rst,
  mersenne_moddiv_if.slave bus
);

  localparam int           CW = $clog2(MAXC+1);
  localparam logic [W-1:0] P  = '1;

  state_t         r_state;
  state_t         w_next;
  logic [1:0]     r_mode;
  logic [W-1:0]   r_x;
  logic [W-1:0]   r_y;
  logic [W-1:0]   r_result;
  logic           r_dbz;
  logic           r_ill;
  logic [CW-1:0]  r_cnt;

  logic [W-1:0]   w_a;
  logic [W-1:0]   w_b;
  logic [W-1:0]   w_inv;
  logic [W-1:0]   w_fold;
  logic [2*W-1:0] w_prod;
  logic [127:0]   w_p128;
  logic           w_accept;
  logic           w_zero;
  logic           w_bad;
  logic           w_needinv;
  logic           w_go;
  logic           w_busy;
  logic           w_fin;
  logic           w_wdog;

  // All-ones is a second encoding of zero.
  assign w_a = (bus.a == P) ? '0 : bus.a;
  assign w_b = (bus.b == P) ? '0 : bus.b;

  assign w_accept  = (r_state == S_IDLE) && bus.start;
  assign w_zero    = (w_b == '0);
  assign w_bad     = (bus.mode == MODE_RSV);
  assign w_needinv = ((bus.mode == MODE_DIV) ||
                      (bus.mode == MODE_INV)) && !w_zero;
  assign w_go      = w_accept && w_needinv;

  assign w_wdog = (r_state == S_INV) && w_busy && !w_fin &&
                  (r_cnt == CW'(MAXC));

  assign w_prod = {{W{1'b0}}, r_x} * {{W{1'b0}}, r_y};
  assign w_p128 = {{(128-2*W){1'b0}}, w_prod};
  assign w_fold = W'(mersenne_fold(w_p128, W));

  mersenne_inv #(
    .W(W)
  ) u_inv (
    .clk (clk),
    .rst (rst),
    .go  (w_go),
    .b   (w_b),
    .busy(w_busy),
    .fin (w_fin),
    .inv (w_inv)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.mode == MODE_MUL) w_next = S_MUL;
          else if (w_needinv)       w_next = S_INV;
          else                      w_next = S_DONE;
        end
      end
      S_INV: begin
        if (w_wdog)
          w_next = S_DONE;
        else if (w_fin)
          w_next = (r_mode == MODE_DIV) ? S_MUL : S_DONE;
      end
      S_MUL:  w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.ready        = (r_state == S_IDLE);
    bus.done         = (r_state == S_DONE);
    bus.result       = r_result;
    bus.div_by_zero  = r_dbz;
    bus.illegal_mode = r_ill;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= MODE_MUL;
      r_x      <= '0;
      r_y      <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
      r_ill    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_x    <= w_a;
            r_y    <= w_b;
            r_mode <= bus.mode;
            r_cnt  <= '0;
            if (w_bad) begin
              r_result <= '0;
              r_dbz    <= 1'b0;
              r_ill    <= 1'b1;
            end else if ((bus.mode != MODE_MUL) && w_zero) begin
              r_result <= '0;
              r_dbz    <= 1'b1;
              r_ill    <= 1'b0;
            end
          end
        end
        S_INV: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_wdog) begin
            r_result <= '0;
            r_dbz    <= 1'b1;
            r_ill    <= 1'b0;
          end else if (w_fin) begin
            // DIV reuses the multiplier with b replaced by its inverse.
            if (r_mode == MODE_DIV) begin
              r_y <= w_inv;
            end else begin
              r_result <= w_inv;
              r_dbz    <= 1'b0;
              r_ill    <= 1'b0;
            end
          end
        end
        S_MUL: begin
          r_result <= w_fold;
          r_dbz    <= 1'b0;
          r_ill    <= 1'b0;
        end
        S_DONE: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mersenne_moddiv.sv
// tb_mersenne_moddiv: W=31 and W=13 units checked against a
// Fermat-inverse / %-based model with latency bounds.
module tb_mersenne_moddiv;

  localparam logic [1:0] M_MUL = 2'b00;
  localparam logic [1:0] M_DIV = 2'b01;
  localparam logic [1:0] M_INV = 2'b10;
  localparam logic [1:0] M_RSV = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mersenne_moddiv_if #(.W(31)) bus31 ();
  mersenne_moddiv_if #(.W(13)) bus13 ();

  mersenne_moddiv #(.W(31)) dut31 (
    .clk(clk),
    .rst(rst),
    .bus(bus31)
  );

  mersenne_moddiv #(.W(13)) dut13 (
    .clk(clk),
    .rst(rst),
    .bus(bus13)
  );

  typedef struct {
    logic [63:0] res;
    logic        dbz;
    logic        ill;
    int          lmin;
    int          lmax;
  } exp_t;

  exp_t q31[$];
  exp_t q13[$];
  int   tests = 0;
  int   fails = 0;
  int   ecnt  = 0;
  int   acc31 = 0;
  int   acc13 = 0;
  bit   got31 = 1'b0;
  bit   got13 = 1'b0;

  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic logic [127:0] mm(
    input logic [127:0] x,
    input logic [127:0] y,
    input logic [127:0] p
  );
    return (x * y) % p;
  endfunction

  // b^(p-2) mod p
  function automatic logic [127:0] pinv(
    input logic [127:0] b,
    input logic [127:0] p
  );
    logic [127:0] r;
    logic [127:0] base;
    logic [127:0] e;
    r    = 128'd1;
    base = b;
    e    = p - 128'd2;
    while (e != 128'd0) begin
      if (e[0]) r = mm(r, base, p);
      base = mm(base, base, p);
      e    = e >> 1;
    end
    return r;
  endfunction

  function automatic exp_t model(
    input int          w,
    input logic [1:0]  m,
    input logic [63:0] a,
    input logic [63:0] b
  );
    exp_t         e;
    logic [127:0] p;
    logic [127:0] x;
    logic [127:0] y;
    logic [127:0] t;
    p = (128'd1 << w) - 128'd1;
    x = ({64'd0, a} == p) ? 128'd0 : {64'd0, a};
    y = ({64'd0, b} == p) ? 128'd0 : {64'd0, b};
    e.res  = '0;
    e.dbz  = 1'b0;
    e.ill  = 1'b0;
    e.lmin = 1;
    e.lmax = 1;
    if (m == M_RSV) begin
      e.ill = 1'b1;
    end else if (m != M_MUL && y == 128'd0) begin
      e.dbz = 1'b1;
    end else if (m == M_MUL) begin
      t = mm(x, y, p);
      e.res = t[63:0];
      e.lmin = 2;
      e.lmax = 2;
    end else if (m == M_INV) begin
      t = pinv(y, p);
      e.res = t[63:0];
      e.lmin = 2;
      e.lmax = 4*w + 6;
    end else begin
      t = mm(x, pinv(y, p), p);
      e.res = t[63:0];
      e.lmin = 3;
      e.lmax = 4*w + 7;
    end
    return e;
  endfunction

  function automatic logic [63:0] rnd(input int w);
    logic [63:0] p;
    int          k;
    p = (64'd1 << w) - 64'd1;
    k = $urandom_range(0, 9);
    if (k == 0) return 64'd0;
    if (k == 1) return p;
    return {$urandom, $urandom} & p;
  endfunction

  task automatic check(
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_rng(
    input string nm,
    input int    act,
    input int    lo,
    input int    hi
  );
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic on_done(
    input int          w,
    input logic [63:0] r,
    input logic        dz,
    input logic        il
  );
    exp_t e;
    int   lat;
    if ((w == 31) ? (q31.size() == 0) : (q13.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL spurious_done_w%0d: got done result %0h, expected no done",
               w, r);
    end else begin
      if (w == 31) begin
        e = q31.pop_front();
        lat = ecnt - acc31 + 1;
        got31 = 1'b1;
      end else begin
        e = q13.pop_front();
        lat = ecnt - acc13 + 1;
        got13 = 1'b1;
      end
      check($sformatf("result_w%0d", w), r, e.res);
      check($sformatf("dbz_w%0d", w), {63'd0, dz}, {63'd0, e.dbz});
      check($sformatf("ill_w%0d", w), {63'd0, il}, {63'd0, e.ill});
      check_rng($sformatf("latency_w%0d", w), lat, e.lmin, e.lmax);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus31.done)
      on_done(31, 64'(bus31.result), bus31.div_by_zero,
              bus31.illegal_mode);
    if (!rst && bus13.done)
      on_done(13, 64'(bus13.result), bus13.div_by_zero,
              bus13.illegal_mode);
  end

  task automatic launch(
    input int          w,
    input logic [1:0]  m,
    input logic [63:0] a,
    input logic [63:0] b
  );
    @(negedge clk);
    if (w == 31) begin
      check("ready31", {63'd0, bus31.ready}, 64'd1);
      q31.push_back(model(31, m, a, b));
      got31 = 1'b0;
      bus31.mode  = m;
      bus31.a     = a[30:0];
      bus31.b     = b[30:0];
      bus31.start = 1'b1;
    end else begin
      check("ready13", {63'd0, bus13.ready}, 64'd1);
      q13.push_back(model(13, m, a, b));
      got13 = 1'b0;
      bus13.mode  = m;
      bus13.a     = a[12:0];
      bus13.b     = b[12:0];
      bus13.start = 1'b1;
    end
    @(posedge clk);
    #1;
    if (w == 31) begin
      acc31 = ecnt;
      bus31.start = 1'b0;
      bus31.a = 31'($urandom);
      bus31.b = 31'($urandom);
    end else begin
      acc13 = ecnt;
      bus13.start = 1'b0;
      bus13.a = 13'($urandom);
      bus13.b = 13'($urandom);
    end
  endtask

  task automatic wait_done(input int w);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4*w + 20; i++) begin
      if ((w == 31 && got31) || (w == 13 && got13)) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL timeout_w%0d: got no done, expected done within %0d edges",
               w, 4*w + 20);
      if (w == 31) q31.delete();
      else         q13.delete();
    end
  endtask

  task automatic run(
    input int          w,
    input logic [1:0]  m,
    input logic [63:0] a,
    input logic [63:0] b
  );
    launch(w, m, a, b);
    wait_done(w);
  endtask

  logic [63:0] r;
  exp_t        pin;

  initial begin
    bus31.start = 1'b0;
    bus31.mode  = M_MUL;
    bus31.a     = '0;
    bus31.b     = '0;
    bus13.start = 1'b0;
    bus13.mode  = M_MUL;
    bus13.a     = '0;
    bus13.b     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready31", {63'd0, bus31.ready}, 64'd1);
    check("rst_done31", {63'd0, bus31.done}, 64'd0);
    check("rst_result31", 64'(bus31.result), 64'd0);
    check("rst_dbz31", {63'd0, bus31.div_by_zero}, 64'd0);
    check("rst_ill31", {63'd0, bus31.illegal_mode}, 64'd0);
    check("rst_ready13", {63'd0, bus13.ready}, 64'd1);
    rst = 1'b0;

    pin = model(31, M_INV, 64'd0, 64'd2);
    check("pin_model_inv31", pin.res, 64'h40000000);
    pin = model(13, M_INV, 64'd0, 64'd2);
    check("pin_model_inv13", pin.res, 64'd4096);
    pin = model(31, M_DIV, 64'd6, 64'd3);
    check("pin_model_div31", pin.res, 64'd2);

    run(31, M_MUL, 64'd2, 64'h40000000);
    check("lit_mul_2x", 64'(bus31.result), 64'd1);
    run(31, M_MUL, 64'h7FFFFFFE, 64'h7FFFFFFE);
    check("lit_mul_m1sq", 64'(bus31.result), 64'd1);
    run(31, M_MUL, 64'h7FFFFFFF, 64'd5);
    check("lit_mul_norm", 64'(bus31.result), 64'd0);

    run(31, M_INV, 64'd0, 64'd2);
    check("lit_inv2", 64'(bus31.result), 64'h40000000);
    run(31, M_DIV, 64'd6, 64'd3);
    check("lit_div63", 64'(bus31.result), 64'd2);
    run(31, M_DIV, 64'd1, 64'h12345678);
    r = 64'(bus31.result);
    run(31, M_MUL, r, 64'h12345678);
    check("lit_div_roundtrip", 64'(bus31.result), 64'd1);

    run(31, M_DIV, 64'd5, 64'd0);
    check("lit_dbz0", {63'd0, bus31.div_by_zero}, 64'd1);
    run(31, M_DIV, 64'd5, 64'h7FFFFFFF);
    check("lit_dbz_ones", {63'd0, bus31.div_by_zero}, 64'd1);
    run(31, M_RSV, 64'd5, 64'd7);
    check("lit_illegal", {63'd0, bus31.illegal_mode}, 64'd1);
    run(31, M_MUL, 64'd3, 64'd4);
    check("lit_flags_clear", {62'd0, bus31.illegal_mode,
                              bus31.div_by_zero}, 64'd0);

    // start while busy must be dropped
    launch(31, M_INV, 64'd0, 64'd3);
    @(negedge clk);
    check("busy_ready31", {63'd0, bus31.ready}, 64'd0);
    bus31.start = 1'b1;
    bus31.mode  = M_MUL;
    bus31.a     = 31'd9;
    bus31.b     = 31'd7;
    @(negedge clk);
    bus31.start = 1'b0;
    wait_done(31);
    repeat (4) @(negedge clk);
    pin = model(31, M_INV, 64'd0, 64'd3);
    check("hold_result31", 64'(bus31.result), pin.res);

    // abort mid-inverse
    run(31, M_INV, 64'd0, 64'd2);
    launch(31, M_DIV, 64'd1, 64'h12345678);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready31", {63'd0, bus31.ready}, 64'd1);
    check("abort_done31", {63'd0, bus31.done}, 64'd0);
    check("abort_result31", 64'(bus31.result), 64'd0);
    check("abort_flags31", {62'd0, bus31.illegal_mode,
                            bus31.div_by_zero}, 64'd0);
    rst = 1'b0;
    q31.delete();
    got31 = 1'b0;
    run(31, M_DIV, 64'd6, 64'd3);
    check("post_abort_div", 64'(bus31.result), 64'd2);

    run(13, M_INV, 64'd0, 64'd2);
    check("lit_inv2_w13", 64'(bus13.result), 64'd4096);
    for (int i = 0; i < 1000; i++)
      run(13, M_DIV, rnd(13), rnd(13));

    for (int i = 0; i < 40; i++)
      run(31, 2'($urandom_range(0, 3)), rnd(31), rnd(31));

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
